cic_comb_mc: RTL and testbench
==============================

CIC_COMB_MC -- requirements
Module: cic_comb_mc

Interface
REQ-001 Parameter WIDTH, default 32: sample and arithmetic width in bits.
REQ-002 Parameter NUM_CH, default 4: number of independent interleaved channels (>=1).
REQ-003 Parameter NUM_STAGES, default 5: number of cascaded comb sections (>=1).
REQ-004 Parameter MAX_DELAY, default 2: maximum differential delay M (>=1).
REQ-005 Derived CHW = max(1, clog2(NUM_CH)); DW = max(1, clog2(MAX_DELAY+1)).
REQ-006 clk_i  in  1  single clock, all logic on rising edge.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 clr_i  in  1  synchronous soft clear of all history and pipeline state.
REQ-009 delay_i  in  DW  differential delay M, quasi-static.
REQ-010 valid_i  in  1  input sample valid.
REQ-011 ready_o  out  1  block accepts input sample this cycle.
REQ-012 ch_i  in  CHW  channel index of input sample.
REQ-013 data_i  in  WIDTH  input sample, two's complement.
REQ-014 valid_o  out  1  output sample valid.
REQ-015 ready_i  in  1  downstream accepts output sample.
REQ-016 ch_o  out  CHW  channel index of output sample.
REQ-017 data_o  out  WIDTH  comb-filtered output sample.

Function
REQ-018 Input transfer when valid_i && ready_o; output transfer when valid_o && ready_i.
REQ-019 stall = valid_o && !ready_i; ready_o = !stall && !clr_i; no combinational path from valid_i to ready_o.
REQ-020 Pipeline has exactly NUM_STAGES register stages, one per comb section; each stage carries valid, channel and WIDTH-bit data.
REQ-021 When !stall, all stages advance one position; when stall, every stage register, all history and all outputs hold unchanged.
REQ-022 Stage s computes y = x - h[s][c][M-1], where x is its input, c its channel, h[s][c][k] the input of stage s for channel c k+1 accepted samples ago.
REQ-023 History h[s][c] is a MAX_DELAY-deep shift register per stage per channel; it shifts (h[0] <= x) only when a valid sample of channel c enters stage s and !stall.
REQ-024 Bubbles (invalid slots) never update history and never produce output.
REQ-025 Subtraction is modulo 2^WIDTH (wrap, no saturation, no growth); CIC integrator wrap cancels.
REQ-026 Effective M = delay_i clamped to [1, MAX_DELAY] (0 -> 1, >MAX_DELAY -> MAX_DELAY).
REQ-027 Changing delay_i takes effect on the next sample processed; history is not cleared; the transient is not specified further.
REQ-028 Latency: sample accepted at cycle t appears on data_o at cycle t+NUM_STAGES absent stall; one sample per cycle throughput.
REQ-029 ch_o equals the ch_i of the sample; sample order is preserved; channels may interleave arbitrarily.
REQ-030 ch_i >= NUM_CH: sample is accepted and passed through with channel tag, data_o unspecified, no history modified.
REQ-031 clr_i high: next edge zeroes all history and all stage valid bits; valid_o = 0 the cycle after; input offered during clr_i is not accepted.
REQ-032 clr_i overrides stall and any in-flight transfer; output transfers pending at clr are dropped.

Reset
REQ-033 rst_i high at a rising edge: all history = 0, all stage valid = 0, stage data and channel = 0.
REQ-034 Outputs after reset: valid_o = 0, data_o = 0, ch_o = 0; ready_o = 1 once rst_i and clr_i are low.
REQ-035 rst_i has priority over clr_i and over all handshake activity; reset mid-stream discards all in-flight samples.

Verification
REQ-036 NUM_STAGES=1, M=1, ch 0 inputs 5, 8, 20 -> data_o 5, 3, 12, each one cycle after acceptance.
REQ-037 NUM_STAGES=1, M=1, interleave ch0:10, ch1:100, ch0:15, ch1:90 -> 10, 100, 5, -10 with ch_o 0, 1, 0, 1.
REQ-038 NUM_STAGES=2, M=2, ch 0 impulse 1 then zeros -> 1, 0, -2, 0, 1, 0, 0, first output 2 cycles after the impulse.
REQ-039 WIDTH=8, M=1, ch 0 inputs 255 then 0 -> 255 then 1 (modulo wrap).
REQ-040 ready_i low 3 cycles with valid_o high -> data_o, ch_o, valid_o stable, ready_o = 0, no history change; resumes in order with no loss.
REQ-041 Stream 7, 9 on ch 0, pulse clr_i, then 4 -> valid_o low after clr, next output 4 (history cleared); same with rst_i.

Source files
------------

// File: rtl/cic_comb_mc.sv
// Multi-channel CIC comb cascade: NUM_STAGES pipelined comb sections with
// per-stage, per-channel delay-line history and valid/ready flow control.
module cic_comb_mc #(
    parameter int WIDTH      = 32,
    parameter int NUM_CH     = 4,
    parameter int NUM_STAGES = 5,
    parameter int MAX_DELAY  = 2,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW  = ($clog2(MAX_DELAY + 1) > 1) ? $clog2(MAX_DELAY + 1) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [DW-1:0]    delay_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [CHW-1:0]   ch_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CHW-1:0]   ch_o,
    output logic [WIDTH-1:0] data_o
);

    logic                  stall_s;
    logic                  take_s;
    logic [DW-1:0]         m_idx_s;

    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [CHW-1:0]        c_q [NUM_STAGES];
    logic [CHW-1:0]        c_d [NUM_STAGES];
    logic [WIDTH-1:0]      d_q [NUM_STAGES];
    logic [WIDTH-1:0]      d_d [NUM_STAGES];
    logic [WIDTH-1:0]      h_q [NUM_STAGES][NUM_CH][MAX_DELAY];
    logic [WIDTH-1:0]      h_d [NUM_STAGES][NUM_CH][MAX_DELAY];

    logic [NUM_STAGES-1:0] xv_s;
    logic [CHW-1:0]        xc_s [NUM_STAGES];
    logic [WIDTH-1:0]      xd_s [NUM_STAGES];
    logic [NUM_STAGES-1:0] hit_s;
    logic [WIDTH-1:0]      hsel_s [NUM_STAGES];

    assign stall_s = v_q[NUM_STAGES-1] && !ready_i;
    assign ready_o = !stall_s && !clr_i;
    assign take_s  = valid_i && ready_o;

    // Clamp M into [1, MAX_DELAY] and convert it to a history tap index (M-1).
    always_comb begin
        if (delay_i == '0) begin
            m_idx_s = '0;
        end else if (delay_i > DW'(MAX_DELAY)) begin
            m_idx_s = DW'(MAX_DELAY - 1);
        end else begin
            m_idx_s = delay_i - DW'(1);
        end
    end

    // Stage inputs: stage 0 sees the accepted sample, later stages the previous register.
    always_comb begin
        xv_s    = '0;
        xv_s[0] = take_s;
        xc_s[0] = ch_i;
        xd_s[0] = data_i;
        for (int s = 1; s < NUM_STAGES; s++) begin
            xv_s[s] = v_q[s-1];
            xc_s[s] = c_q[s-1];
            xd_s[s] = d_q[s-1];
        end
    end

    // Delayed-tap lookup; hit_s is low for channel tags outside the channel range.
    always_comb begin
        hit_s = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            hsel_s[s] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < MAX_DELAY; k++) begin
                    hsel_s[s] = ((xc_s[s] == CHW'(c)) && (m_idx_s == DW'(k))) ?
                                h_q[s][c][k] : hsel_s[s];
                end
                hit_s[s] = hit_s[s] | (xc_s[s] == CHW'(c));
            end
        end
    end

    // Next state: advance every stage and shift the history of valid in-range samples.
    always_comb begin
        v_d = v_q;
        c_d = c_q;
        d_d = d_q;
        h_d = h_q;
        if (!stall_s) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                v_d[s] = xv_s[s];
                c_d[s] = xc_s[s];
                d_d[s] = hit_s[s] ? (xd_s[s] - hsel_s[s]) : xd_s[s];
                for (int c = 0; c < NUM_CH; c++) begin
                    if (xv_s[s] && (xc_s[s] == CHW'(c))) begin
                        h_d[s][c][0] = xd_s[s];
                        for (int k = 1; k < MAX_DELAY; k++) begin
                            h_d[s][c][k] = h_q[s][c][k-1];
                        end
                    end else begin
                        h_d[s][c] = h_q[s][c];
                    end
                end
            end
        end else begin
            v_d = v_q;
        end
    end

    // State registers: reset beats clear, clear beats stall and handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
            c_q <= '{default: '0};
            d_q <= '{default: '0};
            h_q <= '{default: '0};
        end else if (clr_i) begin
            v_q <= '0;
            h_q <= '{default: '0};
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            d_q <= d_d;
            h_q <= h_d;
        end
    end

    assign valid_o = v_q[NUM_STAGES-1];
    assign ch_o    = c_q[NUM_STAGES-1];
    assign data_o  = d_q[NUM_STAGES-1];

endmodule

// File: tb/tb_cic_comb_mc.sv
// Directed bench for cic_comb_mc: three instances (1-stage/3-ch, 2-stage, 8-bit)
// driven from shared inputs; each scenario checks the instance it targets.
module tb_cic_comb_mc;

    logic        clk = 1'b0;
    logic        rst, clr, valid, ready_in;
    logic [1:0]  ch;
    logic [31:0] data;
    logic [1:0]  delay;

    logic        a_rdy, a_v;
    logic [1:0]  a_ch;
    logic [31:0] a_d;
    logic        b_rdy, b_v;
    logic [0:0]  b_ch;
    logic [31:0] b_d;
    logic        c_rdy, c_v;
    logic [0:0]  c_ch;
    logic [7:0]  c_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cic_comb_mc #(.WIDTH(32), .NUM_CH(3), .NUM_STAGES(1), .MAX_DELAY(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .delay_i(delay),
        .valid_i(valid), .ready_o(a_rdy), .ch_i(ch), .data_i(data),
        .valid_o(a_v), .ready_i(ready_in), .ch_o(a_ch), .data_o(a_d));

    cic_comb_mc #(.WIDTH(32), .NUM_CH(2), .NUM_STAGES(2), .MAX_DELAY(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .delay_i(delay),
        .valid_i(valid), .ready_o(b_rdy), .ch_i(ch[0:0]), .data_i(data),
        .valid_o(b_v), .ready_i(ready_in), .ch_o(b_ch), .data_o(b_d));

    cic_comb_mc #(.WIDTH(8), .NUM_CH(2), .NUM_STAGES(1), .MAX_DELAY(2)) dut_c (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .delay_i(delay),
        .valid_i(valid), .ready_o(c_rdy), .ch_i(ch[0:0]), .data_i(data[7:0]),
        .valid_o(c_v), .ready_i(ready_in), .ch_o(c_ch), .data_o(c_d));

    typedef struct {
        logic        v;
        logic [1:0]  ch;
        logic [31:0] d;
        logic [1:0]  m;
        logic        ev;
        logic [1:0]  ech;
        logic [31:0] ed;
        logic        chk_d;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] imp_exp [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; valid = 1'b0; ready_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // ch0 M=1, interleaved ch1/ch2, bubble, delay clamp, out-of-range channel
        vecs[0]  = '{1'b1, 2'd0, 32'd5,   2'd1, 1'b1, 2'd0, 32'd5,          1'b1};
        vecs[1]  = '{1'b1, 2'd0, 32'd8,   2'd1, 1'b1, 2'd0, 32'd3,          1'b1};
        vecs[2]  = '{1'b1, 2'd0, 32'd20,  2'd1, 1'b1, 2'd0, 32'd12,         1'b1};
        vecs[3]  = '{1'b1, 2'd1, 32'd10,  2'd1, 1'b1, 2'd1, 32'd10,         1'b1};
        vecs[4]  = '{1'b1, 2'd2, 32'd100, 2'd1, 1'b1, 2'd2, 32'd100,        1'b1};
        vecs[5]  = '{1'b1, 2'd1, 32'd15,  2'd1, 1'b1, 2'd1, 32'd5,          1'b1};
        vecs[6]  = '{1'b1, 2'd2, 32'd90,  2'd1, 1'b1, 2'd2, 32'hFFFF_FFF6,  1'b1};
        vecs[7]  = '{1'b0, 2'd1, 32'd999, 2'd1, 1'b0, 2'd0, 32'd0,          1'b0};
        vecs[8]  = '{1'b1, 2'd1, 32'd20,  2'd2, 1'b1, 2'd1, 32'd10,         1'b1};
        vecs[9]  = '{1'b1, 2'd1, 32'd20,  2'd0, 1'b1, 2'd1, 32'd0,          1'b1};
        vecs[10] = '{1'b1, 2'd2, 32'd50,  2'd3, 1'b1, 2'd2, 32'hFFFF_FFCE,  1'b1};
        vecs[11] = '{1'b1, 2'd3, 32'd7,   2'd1, 1'b1, 2'd3, 32'd0,          1'b0};
        vecs[12] = '{1'b1, 2'd0, 32'd30,  2'd1, 1'b1, 2'd0, 32'd10,         1'b1};
        imp_exp  = '{32'd1, 32'd0, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'd0, 32'd0};

        ch = 2'd0; data = 32'd0; delay = 2'd1;
        do_reset();
        chk("reset a_valid", {31'd0, a_v}, 32'd0);
        chk("reset a_data", a_d, 32'd0);
        chk("reset a_ch", {30'd0, a_ch}, 32'd0);
        chk("reset a_ready", {31'd0, a_rdy}, 32'd1);
        chk("reset b_valid", {31'd0, b_v}, 32'd0);
        chk("reset b_ch", {31'd0, b_ch}, 32'd0);
        chk("reset b_ready", {31'd0, b_rdy}, 32'd1);
        chk("reset c_valid", {31'd0, c_v}, 32'd0);
        chk("reset c_ch", {31'd0, c_ch}, 32'd0);
        chk("reset c_ready", {31'd0, c_rdy}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            valid = vecs[i].v; ch = vecs[i].ch; data = vecs[i].d; delay = vecs[i].m;
            tick();
            chk($sformatf("vec%0d valid", i), {31'd0, a_v}, {31'd0, vecs[i].ev});
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d ch", i), {30'd0, a_ch}, {30'd0, vecs[i].ech});
                if (vecs[i].chk_d) begin
                    chk($sformatf("vec%0d data", i), a_d, vecs[i].ed);
                end
            end
        end
        valid = 1'b0;

        // Two-stage impulse response with M=2
        do_reset();
        delay = 2'd2; ch = 2'd0; valid = 1'b1; data = 32'd1;
        tick();
        chk("impulse latency", {31'd0, b_v}, 32'd0);
        data = 32'd0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("impulse%0d valid", i), {31'd0, b_v}, 32'd1);
            chk($sformatf("impulse%0d data", i), b_d, imp_exp[i]);
        end
        valid = 1'b0;

        // 8-bit modulo wrap
        do_reset();
        delay = 2'd1; ch = 2'd0; valid = 1'b1; data = 32'd255;
        tick();
        chk("wrap first", {24'd0, c_d}, 32'd255);
        data = 32'd0;
        tick();
        chk("wrap second", {24'd0, c_d}, 32'd1);
        valid = 1'b0;

        // Backpressure: hold for three cycles, then resume without loss
        do_reset();
        delay = 2'd1; ch = 2'd0; valid = 1'b1; data = 32'd10;
        tick();
        chk("stall pre data", a_d, 32'd10);
        ready_in = 1'b0; data = 32'd11;
        #1;
        chk("stall ready_o", {31'd0, a_rdy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d valid", i), {31'd0, a_v}, 32'd1);
            chk($sformatf("stall%0d data", i), a_d, 32'd10);
            chk($sformatf("stall%0d ch", i), {30'd0, a_ch}, 32'd0);
            chk($sformatf("stall%0d ready_o", i), {31'd0, a_rdy}, 32'd0);
        end
        ready_in = 1'b1;
        tick();
        chk("resume first", a_d, 32'd1);
        data = 32'd15;
        tick();
        chk("resume second", a_d, 32'd4);
        valid = 1'b0;

        // Soft clear, clear during stall, then reset mid-stream
        do_reset();
        delay = 2'd1; ch = 2'd0; valid = 1'b1; data = 32'd7;
        tick();
        chk("clr pre 7", a_d, 32'd7);
        data = 32'd9;
        tick();
        chk("clr pre 9", a_d, 32'd2);
        clr = 1'b1;
        #1;
        chk("clr ready_o", {31'd0, a_rdy}, 32'd0);
        tick();
        chk("clr valid", {31'd0, a_v}, 32'd0);
        clr = 1'b0; data = 32'd4;
        tick();
        chk("clr post valid", {31'd0, a_v}, 32'd1);
        chk("clr post data", a_d, 32'd4);
        valid = 1'b0; ready_in = 1'b0; clr = 1'b1;
        tick();
        chk("clr over stall", {31'd0, a_v}, 32'd0);
        clr = 1'b0; ready_in = 1'b1; valid = 1'b1; data = 32'd7;
        tick();
        chk("rst pre 7", a_d, 32'd7);
        data = 32'd9;
        tick();
        chk("rst pre 9", a_d, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst valid", {31'd0, a_v}, 32'd0);
        chk("rst data", a_d, 32'd0);
        data = 32'd4;
        tick();
        chk("rst post data", a_d, 32'd4);
        valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
